fan_seg_reducer: RTL

FAN_SEG_REDUCER -- requirements
Module: fan_seg_reducer

---
 rtl/fan_pkg.sv | 19 +
 rtl/fan_scan_stage.sv | 67 ++++++
 rtl/fan_seg_reducer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fan_pkg.sv
// Shared definitions for the segmented-scan reducer: op encoding and the
// lane combine operator used by every scan stage and by the carry merge.
package fan_pkg;

  localparam logic OP_SUM = 1'b0;
  localparam logic OP_MAX = 1'b1;

  // Widest accumulator supported; callers extend into it and truncate back.
  localparam int ACC_MAX_W = 64;

  typedef logic [ACC_MAX_W-1:0] acc_wide_t;

  function automatic acc_wide_t fan_combine(input logic op, input acc_wide_t a,
                                            input acc_wide_t b);
    if (op == OP_SUM) return a + b;
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fan_scan_stage.sv
// One registered step of a segmented inclusive scan: each lane folds in the
// lane DIST below it unless a segment head lies between them.
module fan_scan_stage
  import fan_pkg::*;
#(
  parameter int N      = 8,
  parameter int DW_ACC = 16,
  parameter int DIST   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              i_valid,
  input  logic              i_op,
  input  logic [N-1:0]      i_seg_end,
  input  logic [N-1:0]      i_head,
  input  logic [N*DW_ACC-1:0] i_val,
  output logic              o_valid,
  output logic              o_op,
  output logic [N-1:0]      o_seg_end,
  output logic [N-1:0]      o_head,
  output logic [N*DW_ACC-1:0] o_val
);

  logic                valid_q, op_q;
  logic [N-1:0]        seg_end_q, head_q, head_d;
  logic [N*DW_ACC-1:0] val_q, val_d;

  // head[i] set means lane i starts a segment, so nothing below it may merge in.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    val_d  = i_val;
    head_d = i_head;
    for (int i = DIST; i < N; i++) begin
      if (!i_head[i]) begin
        val_d[i*DW_ACC +: DW_ACC] = DW_ACC'(fan_combine(i_op,
            ACC_MAX_W'(i_val[(i-DIST)*DW_ACC +: DW_ACC]),
            ACC_MAX_W'(i_val[i*DW_ACC +: DW_ACC])));
      end
      head_d[i] = i_head[i] | i_head[i-DIST];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      op_q      <= 1'b0;
      seg_end_q <= '0;
      head_q    <= '0;
      val_q     <= '0;
    end else if (!hold) begin
      // NOTE: non-blocking so each stage captures its predecessor's pre-edge value.
      valid_q   <= i_valid;
      op_q      <= i_op;
      seg_end_q <= i_seg_end;
      head_q    <= head_d;
      val_q     <= val_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_op      = op_q;
  assign o_seg_end = seg_end_q;
  assign o_head    = head_q;
  assign o_val     = val_q;

endmodule

// File: rtl/fan_seg_reducer.sv
// Segmented sum/max reducer over N lanes per beat: log2(N) scan stages, then a
// final stage that merges the carry of the segment left open by earlier beats.
module fan_seg_reducer
  import fan_pkg::*;
#(
  parameter int DW_DATA = 32,
  parameter int N       = 32,
  parameter int DW_ACC  = 40
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW_DATA*N-1:0] in_data,
  input  logic [N-1:0]        in_seg_end,
  input  logic                in_op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW_ACC*N-1:0] out_data,
  output logic [N-1:0]        out_mask,
  output logic                out_carry_drop
);

  localparam int STAGES = $clog2(N);

  logic                hold;
  logic [N*DW_ACC-1:0] in0_val;

  // Index 0 is the raw input; index s+1 is the output of scan stage s.
  logic                st_valid [STAGES+1];
  logic                st_op    [STAGES+1];
  logic [N-1:0]        st_seg   [STAGES+1];
  logic [N-1:0]        st_head  [STAGES+1];
  logic [N*DW_ACC-1:0] st_val   [STAGES+1];

  logic                out_valid_q, out_valid_d;
  logic [N*DW_ACC-1:0] out_data_q, out_data_d;
  logic [N-1:0]        out_mask_q, out_mask_d;
  logic                out_carry_drop_q, out_carry_drop_d;
  logic [DW_ACC-1:0]   carry_q, carry_d;
  logic                carry_vld_q, carry_vld_d;
  logic                carry_op_q, carry_op_d;
  logic                carry_apply;
  logic [N*DW_ACC-1:0] merged;

  // A stalled result freezes the whole pipe, carry included.
  assign hold     = out_valid_q && !out_ready;
  assign in_ready = !hold;

  always_comb begin
    in0_val = '0;
    for (int i = 0; i < N; i++) begin
      in0_val[i*DW_ACC +: DW_ACC] = DW_ACC'(in_data[i*DW_DATA +: DW_DATA]);
    end
  end

  assign st_valid[0] = in_valid;
  assign st_op[0]    = in_op;
  assign st_seg[0]   = in_seg_end;
  assign st_head[0]  = {in_seg_end[N-2:0], 1'b0};
  assign st_val[0]   = in0_val;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    fan_scan_stage #(
      .N      (N),
      .DW_ACC (DW_ACC),
      .DIST   (1 << s)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .hold      (hold),
      .i_valid   (st_valid[s]),
      .i_op      (st_op[s]),
      .i_seg_end (st_seg[s]),
      .i_head    (st_head[s]),
      .i_val     (st_val[s]),
      .o_valid   (st_valid[s+1]),
      .o_op      (st_op[s+1]),
      .o_seg_end (st_seg[s+1]),
      .o_head    (st_head[s+1]),
      .o_val     (st_val[s+1])
    );
  end

  // After the full scan, head clear marks lanes still in the beat's first segment.
  always_comb begin
    carry_apply = carry_vld_q && (carry_op_q == st_op[STAGES]);
    merged      = st_val[STAGES];
    for (int i = 0; i < N; i++) begin
      if (carry_apply && !st_head[STAGES][i]) begin
        merged[i*DW_ACC +: DW_ACC] = DW_ACC'(fan_combine(st_op[STAGES],
            ACC_MAX_W'(carry_q), ACC_MAX_W'(st_val[STAGES][i*DW_ACC +: DW_ACC])));
      end
    end

    out_valid_d      = out_valid_q;
    out_data_d       = out_data_q;
    out_mask_d       = out_mask_q;
    out_carry_drop_d = 1'b0;
    carry_d          = carry_q;
    carry_vld_d      = carry_vld_q;
    carry_op_d       = carry_op_q;
    if (!hold) begin
      out_valid_d = st_valid[STAGES];
      if (st_valid[STAGES]) begin
        out_data_d       = merged;
        out_mask_d       = st_seg[STAGES];
        out_carry_drop_d = carry_vld_q && !carry_apply;
        if (!st_seg[STAGES][N-1]) begin
          carry_d     = merged[(N-1)*DW_ACC +: DW_ACC];
          carry_vld_d = 1'b1;
          carry_op_d  = st_op[STAGES];
        end else begin
          carry_d     = '0;
          carry_vld_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q      <= 1'b0;
      out_data_q       <= '0;
      out_mask_q       <= '0;
      out_carry_drop_q <= 1'b0;
      carry_q          <= '0;
      carry_vld_q      <= 1'b0;
      carry_op_q       <= 1'b0;
    end else begin
      out_valid_q      <= out_valid_d;
      out_data_q       <= out_data_d;
      out_mask_q       <= out_mask_d;
      out_carry_drop_q <= out_carry_drop_d;
      carry_q          <= carry_d;
      carry_vld_q      <= carry_vld_d;
      carry_op_q       <= carry_op_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_mask       = out_mask_q;
  assign out_carry_drop = out_carry_drop_q;

endmodule
